// File: rtl/axil_regfile.sv
// AXI-lite register file with flat register output and per-register write pulses.
// Optional macro AXIL_REGFILE_SLVERR_EN: out-of-range accesses answer SLVERR.
module axil_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int REG_COUNT  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_WIDTH-1:0]            s_axil_awaddr,
  input  logic [2:0]                       s_axil_awprot,
  input  logic                             s_axil_awvalid,
  output logic                             s_axil_awready,
  input  logic [DATA_WIDTH-1:0]            s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]            s_axil_wstrb,
  input  logic                             s_axil_wvalid,
  output logic                             s_axil_wready,
  output logic [1:0]                       s_axil_bresp,
  output logic                             s_axil_bvalid,
  input  logic                             s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]            s_axil_araddr,
  input  logic [2:0]                       s_axil_arprot,
  input  logic                             s_axil_arvalid,
  output logic                             s_axil_arready,
  output logic [DATA_WIDTH-1:0]            s_axil_rdata,
  output logic [1:0]                       s_axil_rresp,
  output logic                             s_axil_rvalid,
  input  logic                             s_axil_rready,
  output logic [REG_COUNT*DATA_WIDTH-1:0]  reg_out,
  output logic [REG_COUNT-1:0]             reg_wr_pulse
);

  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int OFF_W = $clog2(STRB_WIDTH);
  localparam int HI_W  = IDX_W + OFF_W;
  localparam logic [1:0] RESP_OK = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_OOR = 2'b10;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];
  logic                  r_rdy;
  logic                  r_aw_held;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic                  r_w_held;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_WIDTH-1:0] r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [REG_COUNT-1:0]  r_wr_pulse;

  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_ar_hs;
  logic             w_commit;
  logic [IDX_W-1:0] w_aw_idx;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_aw_in;
  logic             w_ar_in;
  logic             w_unused;

  assign w_unused = ^{s_axil_awprot, s_axil_arprot};

  assign s_axil_awready = r_rdy && !r_aw_held;
  assign s_axil_wready  = r_rdy && !r_w_held;
  assign s_axil_arready = r_rdy && (!r_rvalid || s_axil_rready);

  assign w_aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_w_hs   = s_axil_wvalid && s_axil_wready;
  assign w_ar_hs  = s_axil_arvalid && s_axil_arready;
  assign w_commit = r_aw_held && r_w_held &&
                    (!r_bvalid || s_axil_bready);

  assign w_aw_idx = r_aw_addr[OFF_W +: IDX_W];
  assign w_ar_idx = s_axil_araddr[OFF_W +: IDX_W];
  assign w_aw_in  = (r_aw_addr >> HI_W) == '0;
  assign w_ar_in  = (s_axil_araddr >> HI_W) == '0;

  assign s_axil_bvalid = r_bvalid;
  assign s_axil_bresp  = r_bresp;
  assign s_axil_rvalid = r_rvalid;
  assign s_axil_rresp  = r_rresp;
  assign s_axil_rdata  = r_rdata;
  assign reg_wr_pulse  = r_wr_pulse;

  genvar gi;
  generate
    for (gi = 0; gi < REG_COUNT; gi++) begin : g_out
      assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end
  endgenerate

  // Readies come up one edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy <= 1'b0;
    else        r_rdy <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= s_axil_awaddr;
      end else if (w_commit) begin
        r_aw_held <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= s_axil_wdata;
        r_w_strb <= s_axil_wstrb;
      end else if (w_commit) begin
        r_w_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
      r_wr_pulse <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_aw_in ? RESP_OK : RESP_OOR;
        if (w_aw_in) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (r_w_strb[b])
              r_regs[w_aw_idx][b*8 +: 8] <= r_w_data[b*8 +: 8];
          end
          if (|r_w_strb) r_wr_pulse[w_aw_idx] <= 1'b1;
        end
      end else if (s_axil_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Reads sample the array before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rresp  <= '0;
      r_rdata  <= '0;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_ar_in ? RESP_OK : RESP_OOR;
      r_rdata  <= w_ar_in ? r_regs[w_ar_idx] : '0;
    end else if (s_axil_rready) begin
      r_rvalid <= 1'b0;
    end
  end

endmodule

// File: doc/axil_regfile.md
AXIL_REGFILE -- requirements
Module: axil_regfile

Interface
- REQ-001 Parameter ADDR_WIDTH, default 32: AXI-lite address width.
- REQ-002 Parameter DATA_WIDTH, default 16: AXI-lite data width (16 or 32).
- REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8: byte strobe width.
- REQ-004 Parameter REG_COUNT, default 16: register count, power of two, 2..256.
- REQ-005 Port clk, input, 1: the block's one clock; all logic on its rising edge.
- REQ-006 Port rst_n, input, 1: the reset, asynchronous, active-low.
- REQ-007 Ports s_axil_awaddr/awprot/awvalid/awready, in/in/in/out, ADDR_WIDTH/3/1/1: write address channel (the adapter's m_axil_aw*).
- REQ-008 Ports s_axil_wdata/wstrb/wvalid/wready, in/in/in/out, DATA_WIDTH/STRB_WIDTH/1/1: write data channel.
- REQ-009 Ports s_axil_bresp/bvalid/bready, out/out/in, 2/1/1: write response channel.
- REQ-010 Ports s_axil_araddr/arprot/arvalid/arready, in/in/in/out, ADDR_WIDTH/3/1/1: read address channel.
- REQ-011 Ports s_axil_rdata/rresp/rvalid/rready, out/out/out/in, DATA_WIDTH/2/1/1: read data channel.
- REQ-012 Port reg_out, output, REG_COUNT*DATA_WIDTH: flat register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- REQ-013 Port reg_wr_pulse, output, REG_COUNT: one-cycle pulse per written register.

Function
- REQ-014 Decode: word index = addr bits [log2(STRB_WIDTH) +: log2(REG_COUNT)]; the address is in range iff all bits above the index field are zero; low byte-offset bits are ignored; awprot/arprot are ignored.
- REQ-015 AW and W each have a one-entry holding register; awready = !aw_held and wready = !w_held; AW and W are accepted independently in either order.
- REQ-016 The write commits in the cycle when aw_held && w_held && (!bvalid || bready); it updates each byte with its wstrb bit set, clears both held flags and asserts bvalid on the next cycle.
- REQ-017 Write latency: with AW and W presented together and bready high, bvalid is asserted 2 cycles after the handshake cycle; sustained throughput is one write per 2 cycles.
- REQ-018 bvalid stays high until bready; bresp is constant while bvalid is high.
- REQ-019 reg_wr_pulse[i] is high for exactly the cycle after the commit to register i, provided the address is in range and at least one strobe bit is set.
- REQ-020 arready = !rvalid || rready; on an AR handshake, rdata/rresp are registered and rvalid is asserted the next cycle (1-cycle latency, full throughput).
- REQ-021 rvalid, rdata and rresp hold stable until rready.
- REQ-022 Simultaneous read and write commit to the same register: the read returns the pre-write value.
- REQ-023 In-range accesses return resp OKAY (2'b00).
- REQ-024 wstrb = 0: no register changes, no pulse, and a normal B response.

Reset
- REQ-025 While rst_n is low: all registers = 0; awready = wready = arready = 0; bvalid = rvalid = 0; bresp = rresp = 0; rdata = 0; reg_wr_pulse = 0; held flags cleared.
- REQ-026 Reset asserted mid-transaction discards any held AW/W and any pending B/R response without completing it.
- REQ-027 The ready outputs assert on the first clk edge after rst_n deasserts.

Configuration
- REQ-028 With macro AXIL_REGFILE_SLVERR_EN defined: out-of-range writes are dropped with bresp SLVERR (2'b10), and out-of-range reads return rdata 0 with rresp SLVERR.
- REQ-029 Without AXIL_REGFILE_SLVERR_EN: out-of-range writes are dropped with OKAY; out-of-range reads return rdata 0 with OKAY.

Verification
- REQ-030 Write addr 0x4, data 0xBEEF, wstrb 2'b11 with DATA_WIDTH=16; then read 0x4 -> bresp 0; reg_wr_pulse[2] pulses once; rdata = 0xBEEF, rresp 0.
- REQ-031 W presented 3 cycles before AW, then wstrb 2'b01, data 0x1234 to 0x4 (holding 0xBEEF) -> register = 0xBE34; bvalid appears only after AW arrives.
- REQ-032 bready held low 5 cycles across two back-to-back writes -> the second write does not commit until the first B handshakes; awready/wready stay low while both are held.
- REQ-033 Read of 0x4 and write of 0x5555 to 0x4 in the same cycle -> rdata returns the old value; a subsequent read returns 0x5555.
- REQ-034 Read of 0x1000 (out of range, REG_COUNT=16) -> rdata 0; rresp 2'b10 with AXIL_REGFILE_SLVERR_EN defined, 2'b00 without.
- REQ-035 rst_n pulsed low while bvalid=1 and rvalid=1 -> both drop immediately; reg_out = 0; the next write completes normally.
